// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: FSM state encoding,
// abort cause codes, default framing constants and the checksum rule.
package uart_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CHK     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_CHK_SEED  = 8'h5A;

  // Checksum a sender must append after ADDR and DATA.
  function automatic logic [7:0] frame_checksum(input logic [7:0] addr,
                                                input logic [7:0] data,
                                                input logic [7:0] seed);
    return addr ^ data ^ seed;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input from the UART receiver and register-write / error
// reporting outputs of the command decoder, bundled as one interface.
interface uart_cmd_decoder_if;

  logic       received;
  logic [7:0] rx_byte;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_count;
  logic       busy;

  // Byte source side (receiver or testbench).
  modport master (
    output received, rx_byte,
    input  wr_strobe, wr_addr, wr_data, frame_err, err_code, err_count, busy
  );

  // Decoder side.
  modport slave (
    input  received, rx_byte,
    output wr_strobe, wr_addr, wr_data, frame_err, err_code, err_count, busy
  );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags the
// cycle on which the gap reaches TIMEOUT_CYCLES. Reusable on the TX side.
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [9:0] LAST_COUNT = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] count_q;

  // Gap counter: cleared on demand, otherwise counts up while enabled and
  // parks at all-ones so it can never wrap back into a false expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != 10'h3FF)) begin
      count_q <= count_q + 10'd1;
    end
  end

  assign expire = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles SYNC/ADDR/DATA/CHK frames from the UART receiver byte stream,
// issues a register-write strobe for each valid frame and reports
// checksum and inter-byte timeout aborts.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter logic [7:0] CHK_SEED       = DEFAULT_CHK_SEED,
  parameter int         TIMEOUT_CYCLES = 600
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_decoder_if.slave bus
);

  state_t     state_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       frame_err_q;
  err_t       err_code_q;
  logic [7:0] err_count_q;

  logic gap_clear;
  logic gap_enable;
  logic gap_expire;

  assign gap_clear  = bus.received || (state_q == S_SYNC);
  assign gap_enable = (state_q != S_SYNC);

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (gap_clear),
    .enable (gap_enable),
    .expire (gap_expire)
  );

  // Frame FSM plus all registered outputs; an arriving byte always takes
  // priority over a gap expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      addr_q      <= '0;
      data_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.received) begin
        case (state_q)
          S_SYNC: begin
            if (bus.rx_byte == SYNC_BYTE) begin
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            addr_q  <= bus.rx_byte;
            state_q <= S_DATA;
          end
          S_DATA: begin
            data_q  <= bus.rx_byte;
            state_q <= S_CHK;
          end
          S_CHK: begin
            if (bus.rx_byte == frame_checksum(addr_q, data_q, CHK_SEED)) begin
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= addr_q;
              wr_data_q   <= data_q;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
            state_q <= S_SYNC;
          end
          default: state_q <= S_SYNC;
        endcase
      end else if (gap_expire) begin
        state_q     <= S_SYNC;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;
  assign bus.busy      = (state_q != S_SYNC);

endmodule
